// File: rtl/link_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// link_pkg : shared constants, bus field widths, parity helper, rx states
// Rev 1.0
// ---------------------------------------------------------------------------
package link_pkg;

  localparam logic [15:0] SENTINEL = 16'hFFFF;
  localparam int          D_LO_W   = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_t;

  // 1 when the word has an even number of set bits
  function automatic logic parity_even16(input logic [15:0] x);
    return ~^x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_check.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parity_check : flags a word whose even-parity bit disagrees with its data
// Rev 1.0
// ---------------------------------------------------------------------------
module parity_check
  import link_pkg::*;
(
  input  logic [15:0] i_word,
  input  logic        i_parity_even,
  output logic        o_perr
);

  assign o_perr = i_parity_even ^ parity_even16(i_word);

endmodule
`default_nettype wire

// File: rtl/receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// receiver : req/ack word sink writing parity-checked words to dst memory
// Rev 1.0
// ---------------------------------------------------------------------------
module receiver
  import link_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int WIDTH  = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dst_start,
  input  logic              req,
  input  logic [D_LO_W-1:0] bus_d14_0,
  input  logic              d15_raw,
  input  logic              parity_even,
  output logic              ack,
  output logic              full,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [WIDTH-1:0]  dst_din,
  output logic              dst_we,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic [ERR_W-1:0]  err_count,
  output logic              err_flag
);

  rx_state_t         r_state, w_state_nxt;
  logic              r_perr, w_perr_nxt;
  logic              r_ack, w_ack_nxt;
  logic              r_full, w_full_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [WIDTH-1:0]  r_din, w_din_nxt;
  logic              r_we, w_we_nxt;
  logic              r_done, w_done_nxt;
  logic [ADDR_W:0]   r_cnt, w_cnt_nxt;
  logic [ERR_W-1:0]  r_err, w_err_nxt;
  logic              r_eflag, w_eflag_nxt;

  logic [15:0]       w_bus_word;
  logic              w_perr;

  assign w_bus_word = {d15_raw, bus_d14_0};

  parity_check u_parity_check (
    .i_word        (w_bus_word),
    .i_parity_even (parity_even),
    .o_perr        (w_perr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_perr  <= 1'b0;
      r_ack   <= 1'b0;
      r_full  <= 1'b0;
      r_addr  <= dst_start;
      r_din   <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_eflag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_perr  <= w_perr_nxt;
      r_ack   <= w_ack_nxt;
      r_full  <= w_full_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
      r_we    <= w_we_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_eflag <= w_eflag_nxt;
    end
  end

  // dst_din doubles as the latched word, so the sentinel test reads r_din
  always_comb begin
    w_state_nxt = r_state;
    w_perr_nxt  = r_perr;
    w_ack_nxt   = r_ack;
    w_full_nxt  = r_full;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    w_we_nxt    = 1'b0;
    w_done_nxt  = r_done;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_eflag_nxt = r_eflag;
    case (r_state)
      ST_IDLE: begin
        if (req && !r_full && !r_done) begin
          w_din_nxt   = w_bus_word;
          w_perr_nxt  = w_perr;
          w_we_nxt    = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_perr) begin
          if (r_err != '1) begin
            w_err_nxt = r_err + 1'b1;
          end
          w_eflag_nxt = 1'b1;
        end
        w_ack_nxt   = 1'b1;
        w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (!req) begin
          w_ack_nxt = 1'b0;
          if (r_din == SENTINEL) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_DONE;
          end else if (r_addr == '1) begin
            w_full_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_addr_nxt  = r_addr + 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ack        = r_ack;
  assign full       = r_full;
  assign dst_addr   = r_addr;
  assign dst_din    = r_din;
  assign dst_we     = r_we;
  assign done       = r_done;
  assign word_count = r_cnt;
  assign err_count  = r_err;
  assign err_flag   = r_eflag;

endmodule
`default_nettype wire

// File: tb/tb_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_receiver : randomized transmitter driver with a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_receiver;

  localparam int ADDR_W = 12;
  localparam int WIDTH  = 16;
  localparam int ERR_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] dst_start;
  logic              req;
  logic [14:0]       bus_d14_0;
  logic              d15_raw;
  logic              parity_even;
  logic              ack, full, dst_we, done, err_flag;
  logic [ADDR_W-1:0] dst_addr;
  logic [WIDTH-1:0]  dst_din;
  logic [ADDR_W:0]   word_count;
  logic [ERR_W-1:0]  err_count;

  always #5 clk = ~clk;

  receiver #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .dst_start(dst_start), .req(req),
    .bus_d14_0(bus_d14_0), .d15_raw(d15_raw), .parity_even(parity_even),
    .ack(ack), .full(full), .dst_addr(dst_addr), .dst_din(dst_din),
    .dst_we(dst_we), .done(done), .word_count(word_count),
    .err_count(err_count), .err_flag(err_flag)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model of the link at transaction granularity
  logic [ADDR_W-1:0] m_addr;
  int                m_cnt, m_err;
  bit                m_eflag, m_done, m_full;
  bit                m_valid = 1'b0;
  logic [ADDR_W-1:0] qa[$];
  logic [15:0]       qd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dst_we === 1'b1) begin
        if (qa.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", dst_addr, dst_din);
        end else begin
          check("write_addr", 32'(dst_addr), 32'(qa.pop_front()));
          check("write_data", 32'(dst_din), 32'(qd.pop_front()));
        end
      end
      if (m_valid) begin
        check("word_count", 32'(word_count), m_cnt);
        check("err_count", 32'(err_count), m_err);
        check("err_flag", 32'(err_flag), 32'(m_eflag));
        check("done", 32'(done), 32'(m_done));
        check("full", 32'(full), 32'(m_full));
        check("dst_addr", 32'(dst_addr), 32'(m_addr));
        check("idle_ack", 32'(ack), 0);
      end
    end
  end

  task automatic do_reset(input logic [ADDR_W-1:0] s);
    m_valid   = 1'b0;
    rst       = 1'b1;
    dst_start = s;
    req       = 1'b0;
    repeat (2) @(negedge clk);
    qa.delete();
    qd.delete();
    m_addr  = s;
    m_cnt   = 0;
    m_err   = 0;
    m_eflag = 1'b0;
    m_done  = 1'b0;
    m_full  = 1'b0;
    rst       = 1'b0;
    dst_start = ~s;
    m_valid   = 1'b1;
  endtask

  task automatic drive_bus(input logic [15:0] w, input logic pe);
    bus_d14_0   = w[14:0];
    d15_raw     = w[15];
    parity_even = pe;
  endtask

  task automatic send(input logic [15:0] w, input logic pe, input int hold);
    bit exp_ack;
    int n;
    int we_at;
    exp_ack = !m_full && !m_done;
    m_valid = 1'b0;
    if (exp_ack) begin
      qa.push_back(m_addr);
      qd.push_back(w);
    end
    @(negedge clk);
    req = 1'b1;
    drive_bus(w, pe);
    if (!exp_ack) begin
      repeat (6) begin
        @(negedge clk);
        check("blocked_no_ack", 32'(ack), 0);
      end
      req = 1'b0;
      m_valid = 1'b1;
      return;
    end
    n = 0;
    we_at = 0;
    while (ack !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
      if (dst_we === 1'b1 && we_at == 0) we_at = n;
    end
    check("we_latency", we_at, 1);
    check("ack_latency", n, 2);
    repeat (hold) begin
      @(negedge clk);
      check("ack_held", 32'(ack), 1);
    end
    req = 1'b0;
    drive_bus(16'($urandom), 1'($urandom));
    @(negedge clk);
    check("ack_drop", 32'(ack), 0);
    m_cnt++;
    if (($countones(w) % 2 == 0) != pe) begin
      if (m_err < (1 << ERR_W) - 1) m_err++;
      m_eflag = 1'b1;
    end
    if (w == 16'hFFFF) m_done = 1'b1;
    else if (m_addr == {ADDR_W{1'b1}}) m_full = 1'b1;
    else m_addr = m_addr + 1'b1;
    m_valid = 1'b1;
  endtask

  function automatic logic good_pe(input logic [15:0] w);
    return ($countones(w) % 2) == 0;
  endfunction

  initial begin
    int n;
    logic [15:0] w;
    rst = 1'b1; req = 1'b0; dst_start = '0;
    drive_bus(16'h0000, 1'b0);

    do_reset(12'h010);
    check("rst_ack", 32'(ack), 0);
    check("rst_full", 32'(full), 0);
    check("rst_done", 32'(done), 0);
    check("rst_we", 32'(dst_we), 0);
    check("rst_eflag", 32'(err_flag), 0);
    check("rst_addr", 32'(dst_addr), 32'h010);
    check("rst_din", 32'(dst_din), 0);
    check("rst_wc", 32'(word_count), 0);
    check("rst_ec", 32'(err_count), 0);

    send(16'h1234, 1'b0, 0);
    send(16'h00FF, 1'b1, 0);
    send(16'hFFFF, 1'b1, 0);
    check("seq_done", 32'(done), 1);
    check("seq_wc", 32'(word_count), 3);
    check("seq_ec", 32'(err_count), 0);
    check("seq_addr", 32'(dst_addr), 32'h012);
    send(16'h0055, 1'b1, 0);

    do_reset(12'h100);
    send(16'h8001, 1'b0, 0);
    check("perr_ec", 32'(err_count), 1);
    check("perr_flag", 32'(err_flag), 1);
    send(16'h4321, good_pe(16'h4321), 5);
    check("hold_wc", 32'(word_count), 2);
    check("hold_addr", 32'(dst_addr), 32'h102);

    do_reset(12'hFFE);
    send(16'h0001, 1'b0, 0);
    send(16'h0002, 1'b0, 0);
    check("full_flag", 32'(full), 1);
    check("full_addr", 32'(dst_addr), 32'hFFF);
    send(16'h0003, 1'b1, 2);
    check("full_wc", 32'(word_count), 2);

    do_reset(12'hFFF);
    send(16'hFFFF, 1'b1, 0);
    check("last_sent_done", 32'(done), 1);
    check("last_sent_full", 32'(full), 0);

    do_reset(12'h020);
    m_valid = 1'b0;
    qa.push_back(m_addr);
    qd.push_back(16'h2222);
    @(negedge clk);
    req = 1'b1;
    drive_bus(16'h2222, 1'b1);
    n = 0;
    while (ack !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("mid_ack_seen", 32'(ack), 1);
    rst = 1'b1;
    dst_start = 12'h040;
    @(negedge clk);
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_addr", 32'(dst_addr), 32'h040);
    check("mid_rst_wc", 32'(word_count), 0);
    check("mid_rst_we", 32'(dst_we), 0);
    req = 1'b0;
    do_reset(12'h040);
    send(16'h7777, good_pe(16'h7777), 1);
    check("post_rst_wc", 32'(word_count), 1);

    for (int r = 0; r < 4; r++) begin
      do_reset(12'hFFF - 12'($urandom_range(0, 24)));
      for (int k = 0; k < 30; k++) begin
        w = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
        send(w, 1'($urandom), $urandom_range(0, 3));
      end
    end

    do_reset(12'h000);
    for (int k = 0; k < 300; k++) begin
      w = {1'b0, 15'($urandom)};
      send(w, ~good_pe(w), 0);
    end
    check("sat_ec", 32'(err_count), 255);
    check("sat_flag", 32'(err_flag), 1);
    check("sat_wc", 32'(word_count), 300);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
